afifo_rd_packer: RTL and testbench

- Read-side consumer of the 8-deep, 3-bit asynchronous FIFO. Runs entirely in the FIFO's read clock domain.
- Drains the FIFO by driving its read enable from its empty flag and captures each 3-bit symbol.
- Packs PACK symbols, LSB-first, into one wide word and presents it on a valid/ready output interface.
- A flush request emits a partially filled word at end of stream.

---
 rtl/afifo_rd_packer.sv | 100 ++++++++++
 tb/tb_afifo_rd_packer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_packer.sv
// rtl/afifo_rd_packer.sv - read-side FIFO drainer that packs DW-bit symbols LSB-first into PACK-symbol words
module afifo_rd_packer #(
  parameter int DW   = 3,
  parameter int PACK = 4,
  parameter int CW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty,
  output logic                 ren,
  input  logic [DW-1:0]        din,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW*PACK-1:0]   out_data,
  output logic [CW-1:0]        out_cnt,
  output logic                 busy
);

  localparam int AW = $clog2(PACK + 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DW-1:0]       r_acc [PACK];
  logic [AW-1:0]       r_acc_cnt;
  logic                r_pend;
  logic [DW*PACK-1:0]  r_out_data;
  logic [CW-1:0]       r_out_cnt;
  logic                r_out_valid;

  logic                w_flush_req;
  logic                w_slot_free;
  logic                w_full;
  logic                w_xfer;
  logic                w_ren;
  logic [AW:0]         w_sum;
  logic [DW*PACK-1:0]  w_packed;

  assign w_flush_req = (r_state == DRAIN);
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_full      = (r_acc_cnt == AW'(PACK));
  assign w_sum       = {1'b0, r_acc_cnt} + {{AW{1'b0}}, r_pend};
  assign w_xfer      = w_slot_free &&
                       (w_full || (w_flush_req && !r_pend && (r_acc_cnt != '0)));
  // A symbol in flight counts against the accumulator so capture never overruns it.
  assign w_ren       = !rst && !empty && !w_flush_req &&
                       (w_xfer || (w_sum < (AW + 1)'(PACK)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (flush) w_state_nxt = DRAIN;
      DRAIN:   if (w_xfer || ((r_acc_cnt == '0) && !r_pend)) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_packed = '0;
    for (int k = 0; k < PACK; k++) begin
      if (AW'(k) < r_acc_cnt) w_packed[k*DW +: DW] = r_acc[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_pend      <= 1'b0;
      r_acc_cnt   <= '0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < PACK; k++) r_acc[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_ren;
      if (w_xfer) r_acc_cnt <= '0;
      else if (r_pend) r_acc_cnt <= r_acc_cnt + AW'(1);
      for (int k = 0; k < PACK; k++) begin
        if (r_pend && (r_acc_cnt == AW'(k))) r_acc[k] <= din;
      end
      if (w_xfer) begin
        r_out_data  <= w_packed;
        r_out_cnt   <= CW'(r_acc_cnt);
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign ren       = w_ren;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;
  assign busy      = (r_acc_cnt != '0) || r_pend || w_flush_req;

endmodule

// File: tb/tb_afifo_rd_packer.sv
// tb/tb_afifo_rd_packer.sv - scoreboard bench for afifo_rd_packer with a behavioural FIFO read port
module tb_afifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty;
  logic        ren;
  logic [2:0]  din = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_data;
  logic [2:0]  out_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [11:0] data;
    logic [2:0]  cnt;
  } exp_t;
  exp_t sb[$];

  logic [2:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  always #5 clk = ~clk;

  afifo_rd_packer #(.DW(3), .PACK(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .empty(empty), .ren(ren), .din(din), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .busy(busy)
  );

  // FIFO read port: one-cycle read latency, emptied by the shared reset
  assign empty = (wr_ptr == rd_ptr);
  always @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (ren) begin
      din    <= fifo_mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    n_checks++;
    if (ren && empty) begin
      n_fail++;
      $display("FAIL ren_while_empty: ren=%0b empty=%0b, required ren=0", ren, empty);
    end
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data=%h cnt=%0d, required no word", out_data, out_cnt);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL word: got data=%h cnt=%0d, required data=%h cnt=%0d",
                   out_data, out_cnt, e.data, e.cnt);
        end
      end
    end
  end

  task automatic push_sym(input logic [2:0] v);
    fifo_mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic expect_word(input logic [11:0] d, input logic [2:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int c = 0;
    while (sb.size() != 0 && c < max_cycles) begin
      @(negedge clk); #3;
      c++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    push_sym(3'd5);
    #1;
    n_checks++; if (ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %0b, required 0", ren); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    n_checks++; if (out_data !== 12'h000 || out_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_out: got data=%h cnt=%0d, required 0 0", out_data, out_cnt);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (ren !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got ren=%0b busy=%0b, required 0 0", ren, busy);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    push_sym(3'd1); push_sym(3'd2); push_sym(3'd3); push_sym(3'd4);
    expect_word(12'h8D1, 3'd4);
    #1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c <= 3) begin
        n_checks++; if (ren !== 1'b1) begin n_fail++; $display("FAIL basic_ren_c%0d: got %0b, required 1", c, ren); end
      end else if (c == 4) begin
        n_checks++; if (ren !== 1'b0) begin n_fail++; $display("FAIL basic_ren_idle: got %0b, required 0", ren); end
      end else if (c == 5) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %0b, required 0", out_valid); end
      end else begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b, required 1", out_valid); end
      end
    end
    wait_drain("basic", 20);
  endtask

  task automatic test_stream();
    @(negedge clk);
    for (int i = 0; i < 8; i++) push_sym(3'(i));
    expect_word(12'h688, 3'd4);
    expect_word(12'hFAC, 3'd4);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_checks++; if (ren !== 1'b1) begin n_fail++; $display("FAIL stream_ren_c%0d: got %0b, required 1", c, ren); end
    end
    wait_drain("stream", 40);
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [2:0]  s [12];
    logic [11:0] w [3];
    int          start;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) w[i] = '0;
    for (int i = 0; i < 12; i++) begin
      s[i] = 3'($urandom_range(0, 7));
      w[i/4][(i%4)*3 +: 3] = s[i];
    end
    start = rd_ptr;
    for (int i = 0; i < 12; i++) push_sym(s[i]);
    for (int i = 0; i < 3; i++) expect_word(w[i], 3'd4);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (out_valid) begin
        n_checks++;
        if (out_data !== w[0] || out_cnt !== 3'd4) begin
          n_fail++; $display("FAIL bp_hold: got data=%h cnt=%0d, required data=%h cnt=4", out_data, out_cnt, w[0]);
        end
      end
    end
    n_checks++; if (ren !== 1'b0 || empty !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall: got ren=%0b empty=%0b, required 0 0", ren, empty);
    end
    n_checks++; if (rd_ptr - start != 8) begin
      n_fail++; $display("FAIL bp_pops: got %0d, required 8", rd_ptr - start);
    end
    n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_state: got valid=%0b busy=%0b, required 1 1", out_valid, busy);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain("bp", 40);
  endtask

  task automatic test_flush_partial();
    @(negedge clk);
    push_sym(3'd5); push_sym(3'd6);
    expect_word(12'h035, 3'd2);
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fp_pre: got busy=%0b valid=%0b, required 1 0", busy, out_valid);
    end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fp_drain: got busy=%0b valid=%0b, required 1 0", busy, out_valid);
    end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b1 || out_cnt !== 3'd2) begin
      n_fail++; $display("FAIL fp_emit: got busy=%0b valid=%0b cnt=%0d, required 0 1 2", busy, out_valid, out_cnt);
    end
    wait_drain("fp", 10);
  endtask

  task automatic test_flush_pend();
    @(negedge clk);
    push_sym(3'd1); push_sym(3'd2); push_sym(3'd3); push_sym(3'd7); push_sym(3'd5);
    expect_word(12'h0D1, 3'd3);
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    n_checks++; if (ren !== 1'b0 || empty !== 1'b0) begin
      n_fail++; $display("FAIL fpend_noread: got ren=%0b empty=%0b, required 0 0", ren, empty);
    end
    @(negedge clk); #1;
    n_checks++; if (ren !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fpend_xfer: got ren=%0b valid=%0b, required 0 0", ren, out_valid);
    end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_cnt !== 3'd3) begin
      n_fail++; $display("FAIL fpend_emit: got valid=%0b cnt=%0d, required 1 3", out_valid, out_cnt);
    end
    wait_drain("fpend", 10);
    expect_word(12'h02F, 3'd2);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_drain("fpend_rest", 10);
  endtask

  task automatic test_reset_mid();
    logic [11:0] w;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_sym(3'(i));
    repeat (15) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre: got valid=%0b busy=%0b, required 1 1", out_valid, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || ren !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got valid=%0b ren=%0b busy=%0b, required 0 0 0", out_valid, ren, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    w = '0;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      w[i*3 +: 3] = v;
      push_sym(v);
    end
    expect_word(w, 3'd4);
    wait_drain("rm", 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_pend();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
